// File: rtl/seq_dividend_reconstructor.sv
// Rebuilds a dividend n = q*d + r with a radix-2 shift-add datapath and checks it against a reference.
// Latency: WIDTH+1 clock edges from acceptance to out_valid, fixed and data-independent.
// Backpressure: one operation in flight; in_ready only in IDLE, result held until out_ready.
module seq_dividend_reconstructor #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     q,
   input  logic [WIDTH-1:0]     d,
   input  logic [WIDTH-1:0]     r,
   input  logic [2*WIDTH-1:0]   n_ref,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   n_out,
   output logic [2*WIDTH-1:0]   abs_err,
   output logic                 mismatch
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      CMP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state;
   state_t               state_nxt;

   // Quotient bits are consumed LSB first while the multiplicand walks left.
   logic [WIDTH-1:0]     q_reg;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   n_ref_reg;
   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   diff;
   logic                 accept;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid & in_ready;

   // Unsigned magnitude of the reconstruction error: compare first, then subtract the smaller.
   always_comb begin
      diff = '0;
      if (acc >= n_ref_reg)
         diff = acc - n_ref_reg;
      else
         diff = n_ref_reg - acc;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic: MUL always runs exactly WIDTH cycles, no early exit on zero operands.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)      state_nxt = MUL;
         MUL:     if (cnt == LAST)   state_nxt = CMP;
         CMP:                        state_nxt = DONE;
         DONE:    if (out_ready)     state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture, shift-add multiply with remainder preloaded, compare, and result hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg     <= '0;
         mcand     <= '0;
         acc       <= '0;
         n_ref_reg <= '0;
         cnt       <= '0;
         n_out     <= '0;
         abs_err   <= '0;
         mismatch  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  q_reg     <= q;
                  mcand     <= {{WIDTH{1'b0}}, d};
                  acc       <= {{WIDTH{1'b0}}, r};
                  n_ref_reg <= n_ref;
                  cnt       <= '0;
               end
            end
            MUL: begin
               // Cannot overflow: (2^W-1)^2 + (2^W-1) < 2^(2W).
               if (q_reg[0])
                  acc <= acc + mcand;
               mcand <= mcand << 1;
               q_reg <= q_reg >> 1;
               cnt   <= cnt + CW'(1);
            end
            CMP: begin
               n_out     <= acc;
               abs_err   <= diff;
               mismatch  <= (acc != n_ref_reg);
               out_valid <= 1'b1;
            end
            DONE: begin
               if (out_ready)
                  out_valid <= 1'b0;
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_dividend_reconstructor.sv
// Self-checking bench for seq_dividend_reconstructor against an arithmetic reference model.
// Latency: checks the fixed WIDTH+1 edge acceptance-to-result delay on every operation.
// Backpressure: stalls out_ready and verifies held outputs and blocked in_ready.
module tb_seq_dividend_reconstructor;

   localparam int W = 8;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    q;
   logic [W-1:0]    d;
   logic [W-1:0]    r;
   logic [2*W-1:0]  n_ref;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  n_out;
   logic [2*W-1:0]  abs_err;
   logic            mismatch;

   int checks   = 0;
   int failures = 0;

   seq_dividend_reconstructor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .q         (q),
      .d         (d),
      .r         (r),
      .n_ref     (n_ref),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .n_out     (n_out),
      .abs_err   (abs_err),
      .mismatch  (mismatch)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something upstream never terminates.
   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain arithmetic on the specification's formulas.
   function automatic int model_n(input logic [W-1:0] qi, input logic [W-1:0] di, input logic [W-1:0] ri);
      return int'(qi) * int'(di) + int'(ri);
   endfunction

   function automatic int model_err(input int n, input int nref);
      return (n > nref) ? (n - nref) : (nref - n);
   endfunction

   // Expected result of the operation currently in flight.
   int exp_n;
   int exp_e;
   int exp_m;

   task automatic present(input logic [W-1:0] qi, input logic [W-1:0] di,
                          input logic [W-1:0] ri, input logic [2*W-1:0] ni);
      q        = qi;
      d        = di;
      r        = ri;
      n_ref    = ni;
      in_valid = 1'b1;
      exp_n    = model_n(qi, di, ri);
      exp_e    = model_err(exp_n, int'(ni));
      exp_m    = (exp_n != int'(ni)) ? 1 : 0;
   endtask

   // Called #1 after an edge with operands presented: waits for in_ready, takes the acceptance edge.
   task automatic accept_op(input string tag);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_ready_seen"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      // Scramble operands after acceptance; the result must not depend on them.
      q     = W'($urandom);
      d     = W'($urandom);
      r     = W'($urandom);
      n_ref = (2*W)'($urandom);
      chk({tag, "_busy"}, 32'(in_ready), 32'd0);
   endtask

   // Counts edges from acceptance to out_valid and checks the result against the model.
   task automatic wait_result(input string tag);
      int lat;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(W + 1));
      chk({tag, "_n_out"},    32'(n_out),    32'(exp_n));
      chk({tag, "_abs_err"},  32'(abs_err),  32'(exp_e));
      chk({tag, "_mismatch"}, 32'(mismatch), 32'(exp_m));
   endtask

   // Optional stall with out_ready low, then handshake; checks the return to IDLE.
   task automatic finish_op(input string tag, input int stall);
      if (stall > 0) begin
         out_ready = 1'b0;
         for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
         end
         chk({tag, "_held_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_held_n"},     32'(n_out),     32'(exp_n));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_idle_ready"}, 32'(in_ready),  32'd1);
      chk({tag, "_kept_n"},     32'(n_out),     32'(exp_n));
   endtask

   initial begin
      logic [W-1:0]   rq;
      logic [W-1:0]   rd;
      logic [W-1:0]   rr;
      logic [2*W-1:0] rn;
      int             n2;
      int             e2;

      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      q         = '0;
      d         = '0;
      r         = '0;
      n_ref     = '0;

      // Reset state.
      #1 rst = 1'b1;
      #2;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_n_out",     32'(n_out),     32'd0);
      chk("rst_abs_err",   32'(abs_err),   32'd0);
      chk("rst_mismatch",  32'(mismatch),  32'd0);
      #10 rst = 1'b0;
      @(posedge clk); #1;

      // Basic exact reconstruction.
      present(8'h12, 8'h0D, 8'h05, 16'h00EF);
      accept_op("basic");
      wait_result("basic");
      chk("basic_const_n", 32'(n_out), 32'h00EF);
      finish_op("basic", 0);

      // Error with reference above, then below, the rebuilt value.
      present(8'h03, 8'h07, 8'h02, 16'h001A);
      accept_op("err_hi");
      wait_result("err_hi");
      chk("err_hi_const", 32'(abs_err), 32'h0003);
      finish_op("err_hi", 0);

      present(8'h03, 8'h07, 8'h02, 16'h0010);
      accept_op("err_lo");
      wait_result("err_lo");
      chk("err_lo_const", 32'(abs_err), 32'h0007);
      finish_op("err_lo", 0);

      // Maximum operands, no wrap.
      present(8'hFF, 8'hFF, 8'hFF, 16'hFF00);
      accept_op("max");
      wait_result("max");
      chk("max_const", 32'(n_out), 32'hFF00);
      finish_op("max", 0);

      // Zero divisor still runs the full multiply.
      present(8'hA5, 8'h00, 8'h3C, 16'h0000);
      accept_op("dzero");
      wait_result("dzero");
      chk("dzero_const", 32'(abs_err), 32'h003C);
      finish_op("dzero", 0);

      // Backpressure with a new operand set waiting on in_valid.
      present(8'h21, 8'h09, 8'h04, 16'h0120);
      accept_op("bp1");
      out_ready = 1'b0;
      wait_result("bp1");
      rq = 8'h40; rd = 8'h03; rr = 8'h01; rn = 16'h00C1;
      q = rq; d = rd; r = rr; n_ref = rn; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_in_ready",  32'(in_ready),  32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_n_out",     32'(n_out),     32'(exp_n));
         chk("bp_abs_err",   32'(abs_err),   32'(exp_e));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_ready", 32'(in_ready),  32'd1);
      chk("bp_release_valid", 32'(out_valid), 32'd0);
      present(rq, rd, rr, rn);
      accept_op("bp2");
      wait_result("bp2");
      finish_op("bp2", 0);

      // Randomised operations with random stalls and references near or at the true value.
      for (int k = 0; k < 24; k++) begin
         rq = W'($urandom);
         rd = W'($urandom);
         rr = W'($urandom);
         n2 = model_n(rq, rd, rr);
         case ($urandom_range(0, 2))
            0:       rn = (2*W)'(n2);
            1:       rn = (2*W)'($urandom);
            default: rn = (2*W)'(n2 + int'($urandom_range(0, 6)) - 3);
         endcase
         e2 = model_err(n2, int'(rn));
         present(rq, rd, rr, rn);
         accept_op("rand");
         wait_result("rand");
         chk("rand_err_model", 32'(abs_err), 32'(e2));
         finish_op("rand", int'($urandom_range(0, 3)));
      end

      // Async reset mid-operation, between edges E3 and E4.
      present(8'h11, 8'h22, 8'h33, 16'h0000);
      accept_op("arst");
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_in_ready",  32'(in_ready),  32'd1);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_n_out",     32'(n_out),     32'd0);
      chk("arst_abs_err",   32'(abs_err),   32'd0);
      chk("arst_mismatch",  32'(mismatch),  32'd0);
      #10 rst = 1'b0;
      @(posedge clk); #1;
      chk("arst_no_partial", 32'(out_valid), 32'd0);
      present(8'h02, 8'h03, 8'h01, 16'h0007);
      accept_op("post_rst");
      wait_result("post_rst");
      chk("post_rst_const", 32'(n_out), 32'h0007);
      finish_op("post_rst", 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
